// File: rtl/bcfi_ssp_unit_pkg.sv
// ---------------------------------------------------------------------------
// bcfi_ssp_unit_pkg
//   Shared types and constants for the backward-edge CFI shadow-stack unit.
//   - ssu_op_e    : operation requested of the shadow-stack unit
//   - ssu_state_e : control FSM states
//   - ssu_req_t   : op/data pair as issued by the decode stage
//   - SSU_CAUSE_* : exception cause codes reported on ex_cause_o
// ---------------------------------------------------------------------------
package bcfi_ssp_unit_pkg;

    localparam int unsigned SSU_XLEN = 64;

    typedef enum logic [1:0] {
        SSU_PUSH   = 2'd0,
        SSU_POPCHK = 2'd1,
        SSU_INC    = 2'd2,
        SSU_WRITE  = 2'd3
    } ssu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } ssu_state_e;

    typedef struct packed {
        ssu_op_e                op;
        logic [SSU_XLEN-1:0]    data;
    } ssu_req_t;

    // Misaligned SSP, memory access fault, return-address mismatch
    // (the last one is the software-check cause used by shadow stacks).
    localparam int unsigned SSU_CAUSE_MISALIGN = 6;
    localparam int unsigned SSU_CAUSE_ACCESS   = 7;
    localparam int unsigned SSU_CAUSE_MISMATCH = 18;

endpackage

// File: rtl/bcfi_ssp_unit.sv
// ---------------------------------------------------------------------------
// bcfi_ssp_unit
//   Owner of the architectural shadow-stack pointer. Commits ALU-computed
//   SSP increments, performs shadow-stack push / pop-and-check through a
//   single req/gnt/rvalid memory port and raises a CFI exception when the
//   popped return address does not match. One operation in flight.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   flush_i                 abort any op that has not completed yet
//   xbcfie_i                CFI enable; when low every op is a silent no-op
//   valid_i/op_i/data_i     op request, accepted when valid_i & ready_o
//   ssp_inc_i               ALU result (ssp + imm*SLOT) for SSU_INC
//   ready_o                 unit idle
//   done_o/ex_valid_o       one-cycle completion / fault pulses
//   ex_cause_o              fault cause (valid with ex_valid_o)
//   ssp_o                   current SSP, feeds ALU ssp_i
//   mem_*                   single memory port (store completes on grant)
// ---------------------------------------------------------------------------
module bcfi_ssp_unit
    import bcfi_ssp_unit_pkg::*;
#(
    parameter int unsigned     XLEN      = SSU_XLEN,
    parameter logic [XLEN-1:0] SSP_RESET = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            xbcfie_i,
    input  logic            valid_i,
    input  ssu_op_e         op_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [XLEN-1:0] ssp_inc_i,
    output logic            ready_o,
    output logic            done_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_cause_o,
    output logic [XLEN-1:0] ssp_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i
);

    localparam int unsigned     SLOT_LSB   = $clog2(XLEN / 8);
    localparam logic [XLEN-1:0] SLOT_BYTES = XLEN'(XLEN / 8);

    ssu_state_e      r_state,    w_state_next;
    logic [XLEN-1:0] r_ssp,      w_ssp_next;
    logic [XLEN-1:0] r_addr,     w_addr_next;
    logic [XLEN-1:0] r_data,     w_data_next;     // store data or expected ra
    logic            r_is_push,  w_is_push_next;
    logic            r_done,     w_done_next;
    logic            r_ex_valid, w_ex_valid_next;
    logic [XLEN-1:0] r_ex_cause, w_ex_cause_next;

    logic            w_misaligned;

    assign w_misaligned = (r_ssp[SLOT_LSB-1:0] != '0);

    // -----------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_ssp      <= SSP_RESET;
            r_addr     <= '0;
            r_data     <= '0;
            r_is_push  <= 1'b0;
            r_done     <= 1'b0;
            r_ex_valid <= 1'b0;
            r_ex_cause <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ssp      <= w_ssp_next;
            r_addr     <= w_addr_next;
            r_data     <= w_data_next;
            r_is_push  <= w_is_push_next;
            r_done     <= w_done_next;
            r_ex_valid <= w_ex_valid_next;
            r_ex_cause <= w_ex_cause_next;
        end
    end

    // -----------------------------------------------------------------
    // Next-state and commit logic
    // -----------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_ssp_next      = r_ssp;
        w_addr_next     = r_addr;
        w_data_next     = r_data;
        w_is_push_next  = r_is_push;
        w_done_next     = 1'b0;
        w_ex_valid_next = 1'b0;
        w_ex_cause_next = '0;

        unique case (r_state)
            S_IDLE: begin
                // A flush in the same cycle as valid_i kills the request.
                if (valid_i && !flush_i) begin
                    if (!xbcfie_i) begin
                        w_done_next = 1'b1;
                    end else begin
                        unique case (op_i)
                            SSU_INC: begin
                                w_ssp_next  = ssp_inc_i;
                                w_done_next = 1'b1;
                            end
                            SSU_WRITE: begin
                                w_ssp_next  = data_i;
                                w_done_next = 1'b1;
                            end
                            default: begin // SSU_PUSH, SSU_POPCHK
                                if (w_misaligned) begin
                                    w_done_next     = 1'b1;
                                    w_ex_valid_next = 1'b1;
                                    w_ex_cause_next = XLEN'(SSU_CAUSE_MISALIGN);
                                end else begin
                                    // Stack grows down: push pre-decrements,
                                    // pop reads the current top slot.
                                    w_is_push_next = (op_i == SSU_PUSH);
                                    w_addr_next    = (op_i == SSU_PUSH) ? (r_ssp - SLOT_BYTES) : r_ssp;
                                    w_data_next    = data_i;
                                    w_state_next   = S_REQ;
                                end
                            end
                        endcase
                    end
                end
            end

            S_REQ: begin
                if (mem_gnt_i) begin
                    if (r_is_push) begin
                        // The store is already on its way to memory; a flush
                        // only suppresses the architectural commit.
                        w_state_next = S_IDLE;
                        if (!flush_i) begin
                            w_done_next = 1'b1;
                            if (mem_err_i) begin
                                w_ex_valid_next = 1'b1;
                                w_ex_cause_next = XLEN'(SSU_CAUSE_ACCESS);
                            end else begin
                                w_ssp_next = r_addr;
                            end
                        end
                    end else begin
                        // A load response is still owed; drain it on flush.
                        w_state_next = flush_i ? S_DRAIN : S_WAIT;
                    end
                end else if (flush_i) begin
                    w_state_next = S_IDLE;
                end
            end

            S_WAIT: begin
                if (flush_i) begin
                    w_state_next = mem_rvalid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid_i) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                    if (mem_err_i) begin
                        w_ex_valid_next = 1'b1;
                        w_ex_cause_next = XLEN'(SSU_CAUSE_ACCESS);
                    end else if (mem_rdata_i != r_data) begin
                        w_ex_valid_next = 1'b1;
                        w_ex_cause_next = XLEN'(SSU_CAUSE_MISMATCH);
                    end else begin
                        w_ssp_next = r_addr + SLOT_BYTES;
                    end
                end
            end

            S_DRAIN: begin
                if (mem_rvalid_i) begin
                    w_state_next = S_IDLE;
                end
            end

            default: w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------
    assign ready_o     = (r_state == S_IDLE);
    assign done_o      = r_done;
    assign ex_valid_o  = r_ex_valid;
    assign ex_cause_o  = r_ex_cause;
    assign ssp_o       = r_ssp;
    assign mem_req_o   = (r_state == S_REQ);
    assign mem_we_o    = mem_req_o & r_is_push;
    assign mem_addr_o  = mem_req_o ? r_addr : '0;
    assign mem_wdata_o = mem_we_o ? r_data : '0;

endmodule

// File: tb/tb_bcfi_ssp_unit.sv
// ---------------------------------------------------------------------------
// tb_bcfi_ssp_unit
//   Directed self-checking bench for bcfi_ssp_unit (XLEN=64, SLOT=8 bytes).
// ---------------------------------------------------------------------------
module tb_bcfi_ssp_unit;
    import bcfi_ssp_unit_pkg::*;

    localparam int XLEN = 64;

    logic            clk_i;
    logic            rst_ni;
    logic            flush_i;
    logic            xbcfie_i;
    logic            valid_i;
    ssu_op_e         op_i;
    logic [XLEN-1:0] data_i;
    logic [XLEN-1:0] ssp_inc_i;
    logic            ready_o;
    logic            done_o;
    logic            ex_valid_o;
    logic [XLEN-1:0] ex_cause_o;
    logic [XLEN-1:0] ssp_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            mem_err_i;

    int n_cmp = 0;
    int n_err = 0;

    bcfi_ssp_unit #(.XLEN(XLEN), .SSP_RESET('0)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .xbcfie_i    (xbcfie_i),
        .valid_i     (valid_i),
        .op_i        (op_i),
        .data_i      (data_i),
        .ssp_inc_i   (ssp_inc_i),
        .ready_o     (ready_o),
        .done_o      (done_o),
        .ex_valid_o  (ex_valid_o),
        .ex_cause_o  (ex_cause_o),
        .ssp_o       (ssp_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_err_i   (mem_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request for exactly one cycle.
    task automatic issue(input ssu_op_e op, input logic [XLEN-1:0] data,
                         input logic [XLEN-1:0] inc, input logic en, input logic fl);
        valid_i   = 1'b1;
        op_i      = op;
        data_i    = data;
        ssp_inc_i = inc;
        xbcfie_i  = en;
        flush_i   = fl;
        tick();
        valid_i   = 1'b0;
        flush_i   = 1'b0;
        xbcfie_i  = 1'b1;
    endtask

    task automatic set_ssp(input logic [XLEN-1:0] v);
        issue(SSU_WRITE, v, '0, 1'b1, 1'b0);
        check_eq("write_ssp", ssp_o, v);
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; xbcfie_i = 1'b1; valid_i = 1'b0;
        op_i = SSU_PUSH; data_i = '0; ssp_inc_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // Reset state
        check_eq("rst_ready", 64'(ready_o), 64'd1);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_ssp", ssp_o, 64'h0);
        check_eq("rst_req", 64'(mem_req_o), 64'd0);
        check_eq("rst_cause", ex_cause_o, 64'h0);

        // PUSH with grant two cycles after the request
        set_ssp(64'h1000);
        issue(SSU_PUSH, 64'h8000_1234, '0, 1'b1, 1'b0);
        check_eq("push_req", 64'(mem_req_o), 64'd1);
        check_eq("push_we", 64'(mem_we_o), 64'd1);
        check_eq("push_addr", mem_addr_o, 64'hFF8);
        check_eq("push_wdata", mem_wdata_o, 64'h8000_1234);
        check_eq("push_ready", 64'(ready_o), 64'd0);
        tick();
        check_eq("push_hold_addr", mem_addr_o, 64'hFF8);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check_eq("push_done", 64'(done_o), 64'd1);
        check_eq("push_ex", 64'(ex_valid_o), 64'd0);
        check_eq("push_ssp", ssp_o, 64'hFF8);
        check_eq("push_req_off", 64'(mem_req_o), 64'd0);
        tick();
        check_eq("push_done_pulse", 64'(done_o), 64'd0);

        // POPCHK matching
        issue(SSU_POPCHK, 64'h8000_1234, '0, 1'b1, 1'b0);
        check_eq("pop_addr", mem_addr_o, 64'hFF8);
        check_eq("pop_we", 64'(mem_we_o), 64'd0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check_eq("pop_wait_done", 64'(done_o), 64'd0);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h8000_1234;
        tick();
        mem_rvalid_i = 1'b0;
        check_eq("pop_done", 64'(done_o), 64'd1);
        check_eq("pop_ex", 64'(ex_valid_o), 64'd0);
        check_eq("pop_ssp", ssp_o, 64'h1000);

        // POPCHK mismatch
        set_ssp(64'hFF8);
        issue(SSU_POPCHK, 64'h8000_1234, '0, 1'b1, 1'b0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h8000_1238;
        tick();
        mem_rvalid_i = 1'b0;
        check_eq("mm_done", 64'(done_o), 64'd1);
        check_eq("mm_ex", 64'(ex_valid_o), 64'd1);
        check_eq("mm_cause", ex_cause_o, 64'd18);
        check_eq("mm_ssp", ssp_o, 64'hFF8);

        // SSU_INC, then INC with BCFI disabled
        issue(SSU_INC, '0, 64'h1040, 1'b1, 1'b0);
        check_eq("inc_done", 64'(done_o), 64'd1);
        check_eq("inc_ssp", ssp_o, 64'h1040);
        check_eq("inc_req", 64'(mem_req_o), 64'd0);
        issue(SSU_INC, '0, 64'h2000, 1'b0, 1'b0);
        check_eq("dis_done", 64'(done_o), 64'd1);
        check_eq("dis_ex", 64'(ex_valid_o), 64'd0);
        check_eq("dis_ssp", ssp_o, 64'h1040);
        issue(SSU_PUSH, 64'h55, '0, 1'b0, 1'b0);
        check_eq("dis_push_req", 64'(mem_req_o), 64'd0);
        check_eq("dis_push_ssp", ssp_o, 64'h1040);

        // Misaligned PUSH
        set_ssp(64'h1004);
        issue(SSU_PUSH, 64'h77, '0, 1'b1, 1'b0);
        check_eq("mis_done", 64'(done_o), 64'd1);
        check_eq("mis_ex", 64'(ex_valid_o), 64'd1);
        check_eq("mis_cause", ex_cause_o, 64'd6);
        check_eq("mis_req", 64'(mem_req_o), 64'd0);
        check_eq("mis_ssp", ssp_o, 64'h1004);
        tick();
        check_eq("mis_req_after", 64'(mem_req_o), 64'd0);

        // PUSH access fault
        set_ssp(64'h1000);
        issue(SSU_PUSH, 64'h99, '0, 1'b1, 1'b0);
        mem_gnt_i = 1'b1; mem_err_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_err_i = 1'b0;
        check_eq("acc_ex", 64'(ex_valid_o), 64'd1);
        check_eq("acc_cause", ex_cause_o, 64'd7);
        check_eq("acc_ssp", ssp_o, 64'h1000);

        // Flush in REQ before grant
        issue(SSU_PUSH, 64'h99, '0, 1'b1, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_eq("flreq_done", 64'(done_o), 64'd0);
        check_eq("flreq_req", 64'(mem_req_o), 64'd0);
        check_eq("flreq_ready", 64'(ready_o), 64'd1);
        check_eq("flreq_ssp", ssp_o, 64'h1000);

        // Flush together with valid: not accepted
        issue(SSU_WRITE, 64'h3000, '0, 1'b1, 1'b1);
        check_eq("flval_done", 64'(done_o), 64'd0);
        check_eq("flval_ssp", ssp_o, 64'h1000);

        // Flush in WAIT, rvalid three cycles later
        issue(SSU_POPCHK, 64'h8000_1234, '0, 1'b1, 1'b0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_eq("flw_ready", 64'(ready_o), 64'd0);
        check_eq("flw_done", 64'(done_o), 64'd0);
        tick(); tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h8000_1234;
        tick();
        mem_rvalid_i = 1'b0;
        check_eq("flw_done_rv", 64'(done_o), 64'd0);
        check_eq("flw_ready_rv", 64'(ready_o), 64'd1);
        check_eq("flw_ssp", ssp_o, 64'h1000);

        // Reset while in WAIT; late rvalid ignored
        issue(SSU_POPCHK, 64'h8000_1234, '0, 1'b1, 1'b0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        check_eq("rw_ready_before", 64'(ready_o), 64'd0);
        rst_ni = 1'b0;
        #2;
        check_eq("rw_ssp", ssp_o, 64'h0);
        check_eq("rw_ready", 64'(ready_o), 64'd1);
        check_eq("rw_req", 64'(mem_req_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'h8000_1234;
        tick();
        mem_rvalid_i = 1'b0;
        check_eq("rw_late_done", 64'(done_o), 64'd0);
        check_eq("rw_late_ssp", ssp_o, 64'h0);
        check_eq("rw_late_ready", 64'(ready_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
